keypad_scanner: RTL and testbench

//  Input-side counterpart of the multiplexed seg7 display driver. Scans a 4x4 matrix keypad on a

---
 rtl/keypad_scanner.sv | 151 +++++++++++++++
 tb/tb_keypad_scanner.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with frame debounce and a 4-entry key-press FIFO
// Ports:
//   clk        system clock
//   reset      synchronous, active-low
//   col_o      column drive, active-low, one column at a time, 4'b1111 when idle
//   row_i      row sense, active-low, asynchronous
//   key_down   debounced key map, bit col*4+row set while held
//   key_code   FIFO head code (col*4+row), 0 when empty
//   key_valid  FIFO non-empty
//   key_rd     pop request, ignored when empty
//   fifo_cnt   entries held, 0..4
//   overflow   sticky flag for a press dropped on a full FIFO
//   clr_ovf    clears overflow; a simultaneous drop keeps it set
module keypad_scanner #(
  parameter logic [15:0] SCAN_DIV        = 16'd1000,
  parameter logic [7:0]  DEBOUNCE_FRAMES = 8'd4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [3:0]  col_o,
  input  logic [3:0]  row_i,
  output logic [15:0] key_down,
  output logic [3:0]  key_code,
  output logic        key_valid,
  input  logic        key_rd,
  output logic [2:0]  fifo_cnt,
  output logic        overflow,
  input  logic        clr_ovf
);
  typedef enum logic [1:0] {SCAN, EVAL, EVENT} state_t;
  state_t st_q, st_d;
  logic [3:0] sync1_q, sync2_q, rs;
  logic [3:0] col_q, col_d;
  logic [1:0] c_q, c_d;
  logic [15:0] div_q, div_d;
  logic [15:0] frame_q, frame_d, prev_q, prev_d;
  logic [15:0] key_down_q, key_down_d, new_press_q, new_press_d;
  logic [7:0] dbc_q, dbc_d, dbc_inc;
  logic [3:0] idx_q, idx_d;
  logic [3:0][3:0] mem_q, mem_d;
  logic [1:0] wp_q, wp_d, rp_q, rp_d;
  logic [2:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic push, pop, accept;
  always_comb begin
    rs = ~sync2_q;
    st_d = st_q;
    c_d = c_q;
    div_d = div_q;
    frame_d = frame_q;
    prev_d = prev_q;
    dbc_d = dbc_q;
    key_down_d = key_down_q;
    new_press_d = new_press_q;
    idx_d = idx_q;
    dbc_inc = dbc_q + 8'd1;
    case (st_q)
      SCAN: begin
        div_d = div_q + 16'd1;
        if (div_q == SCAN_DIV - 16'd1) begin
          div_d = '0;
          frame_d[{c_q, 2'b00} +: 4] = rs;
          c_d = c_q + 2'd1;
          st_d = (c_q == 2'd3) ? EVAL : SCAN;
        end
      end
      EVAL: begin
        prev_d = frame_q;
        st_d = SCAN;
        c_d = '0;
        div_d = '0;
        if (frame_q != prev_q)
          dbc_d = '0;
        else if (dbc_q < DEBOUNCE_FRAMES) begin
          dbc_d = dbc_inc;
          if (dbc_inc == DEBOUNCE_FRAMES && frame_q != key_down_q) begin
            new_press_d = frame_q & ~key_down_q;
            key_down_d = frame_q;
            idx_d = '0;
            st_d = EVENT;
          end
        end
      end
      default: begin
        idx_d = idx_q + 4'd1;
        c_d = '0;
        div_d = '0;
        st_d = (idx_q == 4'd15) ? SCAN : EVENT;
      end
    endcase
    col_d = (st_d == SCAN) ? ~(4'b0001 << c_d) : 4'b1111;
  end
  always_comb begin
    pop = key_rd && (cnt_q != 3'd0);
    push = (st_q == EVENT) && new_press_q[idx_q];
    accept = push && ((cnt_q != 3'd4) || pop);
    mem_d = mem_q;
    if (accept) mem_d[wp_q] = idx_q;
    wp_d = wp_q + {1'b0, accept};
    rp_d = rp_q + {1'b0, pop};
    cnt_d = cnt_q + {2'b00, accept} - {2'b00, pop};
    ovf_d = (push && !accept) || (ovf_q && !clr_ovf);
  end
  // Reset parks the FSM on the last EVENT step (with nothing pending) so the
  // first active edge starts a full-length column 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 4'hf;
      sync2_q <= 4'hf;
      st_q <= EVENT;
      idx_q <= 4'd15;
      c_q <= '0;
      div_q <= '0;
      col_q <= 4'hf;
      frame_q <= '0;
      prev_q <= '0;
      dbc_q <= '0;
      key_down_q <= '0;
      new_press_q <= '0;
      mem_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sync1_q <= row_i;
      sync2_q <= sync1_q;
      st_q <= st_d;
      idx_q <= idx_d;
      c_q <= c_d;
      div_q <= div_d;
      col_q <= col_d;
      frame_q <= frame_d;
      prev_q <= prev_d;
      dbc_q <= dbc_d;
      key_down_q <= key_down_d;
      new_press_q <= new_press_d;
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
  assign col_o = col_q;
  assign key_down = key_down_q;
  assign key_valid = cnt_q != 3'd0;
  assign key_code = key_valid ? mem_q[rp_q] : 4'd0;
  assign fifo_cnt = cnt_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with a behavioural 4x4 keypad
module tb_keypad_scanner;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] col_o, row_i;
  logic [15:0] key_down;
  logic [3:0] key_code;
  logic key_valid, key_rd = 1'b0, clr_ovf = 1'b0, overflow;
  logic [2:0] fifo_cnt;
  logic [15:0] pressed = '0;
  int vectors = 0;
  int errors = 0;
  keypad_scanner #(.SCAN_DIV(16'd4), .DEBOUNCE_FRAMES(8'd2)) dut (
    .clk(clk), .reset(reset), .col_o(col_o), .row_i(row_i), .key_down(key_down),
    .key_code(key_code), .key_valid(key_valid), .key_rd(key_rd), .fifo_cnt(fifo_cnt),
    .overflow(overflow), .clr_ovf(clr_ovf)
  );
  always #5 clk = ~clk;
  always_comb begin
    row_i = 4'hf;
    for (int c = 0; c < 4; c++)
      if (!col_o[c]) row_i = row_i & ~pressed[c*4 +: 4];
  end
  task automatic wait_col(input logic [3:0] prior, input logic [3:0] pat);
    logic [3:0] p;
    int n;
    p = col_o;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (col_o == pat && p == prior) break;
      p = col_o;
    end
    if (n == 200) begin
      vectors++;
      errors++;
      $display("FAIL wait_col_timeout: col_o %b never followed %b", pat, prior);
    end
  endtask
  task automatic wait_sof();
    wait_col(4'b1111, 4'b1110);
  endtask
  task automatic wait_eval();
    wait_col(4'b0111, 4'b1111);
  endtask
  task automatic pulse_rd();
    key_rd = 1'b1;
    @(negedge clk);
    key_rd = 1'b0;
  endtask
  task automatic test_reset();
    logic [3:0] exp;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({col_o, key_down, key_code, key_valid, fifo_cnt, overflow} !== {4'hf, 16'h0, 4'h0, 1'b0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got col=%b kd=%h code=%h v=%b cnt=%0d ovf=%b", col_o, key_down, key_code, key_valid, fifo_cnt, overflow);
    end
    reset = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      exp = (n == 17) ? 4'b1111 : ~(4'b0001 << ((n - 1) / 4));
      vectors++;
      if (col_o !== exp) begin
        errors++;
        $display("FAIL col_step[%0d]: got %b want %b", n, col_o, exp);
      end
    end
    vectors++;
    if ({key_down, key_valid, fifo_cnt, overflow} !== {16'h0, 1'b0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL idle_frame: got kd=%h v=%b cnt=%0d ovf=%b", key_down, key_valid, fifo_cnt, overflow);
    end
  endtask
  task automatic test_press();
    wait_sof();
    pressed = 16'h0200;
    wait_eval();
    wait_eval();
    wait_eval();
    vectors++;
    if (key_down !== 16'h0000) begin
      errors++;
      $display("FAIL press_before_update: got %h want 0000", key_down);
    end
    @(negedge clk);
    vectors++;
    if ({key_down, fifo_cnt} !== {16'h0200, 3'd0}) begin
      errors++;
      $display("FAIL press_update: got kd=%h cnt=%0d want 0200 0", key_down, fifo_cnt);
    end
    repeat (15) @(negedge clk);
    vectors++;
    if ({col_o, fifo_cnt, key_code} !== {4'b1111, 3'd1, 4'd9}) begin
      errors++;
      $display("FAIL event_last: got col=%b cnt=%0d code=%0d want 1111 1 9", col_o, fifo_cnt, key_code);
    end
    @(negedge clk);
    vectors++;
    if ({col_o, key_valid, fifo_cnt, key_code} !== {4'b1110, 1'b1, 3'd1, 4'd9}) begin
      errors++;
      $display("FAIL event_end: got col=%b v=%b cnt=%0d code=%0d want 1110 1 1 9", col_o, key_valid, fifo_cnt, key_code);
    end
    pressed = 16'h0000;
    repeat (3) wait_sof();
    vectors++;
    if ({key_down, fifo_cnt, key_code} !== {16'h0000, 3'd1, 4'd9}) begin
      errors++;
      $display("FAIL release: got kd=%h cnt=%0d code=%0d want 0000 1 9", key_down, fifo_cnt, key_code);
    end
    pulse_rd();
    vectors++;
    if ({key_valid, fifo_cnt, key_code} !== {1'b0, 3'd0, 4'd0}) begin
      errors++;
      $display("FAIL pop_one: got v=%b cnt=%0d code=%0d want 0 0 0", key_valid, fifo_cnt, key_code);
    end
    pulse_rd();
    vectors++;
    if ({key_valid, fifo_cnt} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL pop_empty: got v=%b cnt=%0d want 0 0", key_valid, fifo_cnt);
    end
  endtask
  task automatic test_bounce();
    logic [5:0] pat;
    pat = 6'b110011;
    wait_sof();
    for (int f = 0; f < 6; f++) begin
      pressed = pat[f] ? 16'h0040 : 16'h0000;
      wait_sof();
      vectors++;
      if ({key_down, fifo_cnt} !== {16'h0000, 3'd0}) begin
        errors++;
        $display("FAIL bounce[%0d]: got kd=%h cnt=%0d want 0000 0", f, key_down, fifo_cnt);
      end
    end
    wait_sof();
    vectors++;
    if ({key_down, fifo_cnt, key_code} !== {16'h0040, 3'd1, 4'd6}) begin
      errors++;
      $display("FAIL bounce_settle: got kd=%h cnt=%0d code=%0d want 0040 1 6", key_down, fifo_cnt, key_code);
    end
    repeat (3) wait_sof();
    vectors++;
    if (fifo_cnt !== 3'd1) begin
      errors++;
      $display("FAIL bounce_single_push: got %0d want 1", fifo_cnt);
    end
    pulse_rd();
    pressed = 16'h0000;
    repeat (3) wait_sof();
    vectors++;
    if ({key_down, fifo_cnt} !== {16'h0000, 3'd0}) begin
      errors++;
      $display("FAIL bounce_release: got kd=%h cnt=%0d want 0000 0", key_down, fifo_cnt);
    end
  endtask
  task automatic test_back_to_back();
    wait_sof();
    pressed = 16'h0022;
    wait_eval();
    wait_eval();
    wait_eval();
    repeat (6) @(negedge clk);
    vectors++;
    if ({fifo_cnt, key_code} !== {3'd1, 4'd1}) begin
      errors++;
      $display("FAIL two_first: got cnt=%0d code=%0d want 1 1", fifo_cnt, key_code);
    end
    pulse_rd();
    vectors++;
    if ({fifo_cnt, key_code} !== {3'd1, 4'd5}) begin
      errors++;
      $display("FAIL push_pop_same: got cnt=%0d code=%0d want 1 5", fifo_cnt, key_code);
    end
    wait_sof();
    pulse_rd();
    vectors++;
    if ({key_valid, fifo_cnt} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL two_drain: got v=%b cnt=%0d want 0 0", key_valid, fifo_cnt);
    end
    pressed = 16'h0000;
    repeat (3) wait_sof();
  endtask
  task automatic test_overflow();
    logic [3:0] exp;
    wait_sof();
    pressed = 16'h7c00;
    repeat (3) wait_sof();
    vectors++;
    if ({fifo_cnt, overflow, key_valid, key_code} !== {3'd4, 1'b1, 1'b1, 4'd10}) begin
      errors++;
      $display("FAIL overflow_set: got cnt=%0d ovf=%b v=%b code=%0d want 4 1 1 10", fifo_cnt, overflow, key_valid, key_code);
    end
    pressed = 16'hfc00;
    wait_eval();
    wait_eval();
    wait_eval();
    repeat (16) @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    vectors++;
    if ({overflow, fifo_cnt, key_code} !== {1'b1, 3'd4, 4'd10}) begin
      errors++;
      $display("FAIL clr_with_drop: got ovf=%b cnt=%0d code=%0d want 1 4 10", overflow, fifo_cnt, key_code);
    end
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    vectors++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL clr_alone: got %b want 0", overflow);
    end
    for (int k = 0; k < 4; k++) begin
      exp = 4'd10 + 4'(k);
      vectors++;
      if (key_code !== exp) begin
        errors++;
        $display("FAIL drain[%0d]: got %0d want %0d", k, key_code, exp);
      end
      pulse_rd();
    end
    vectors++;
    if ({key_valid, fifo_cnt, overflow} !== {1'b0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL drain_empty: got v=%b cnt=%0d ovf=%b want 0 0 0", key_valid, fifo_cnt, overflow);
    end
  endtask
  task automatic test_reset_in_event();
    wait_sof();
    pressed = 16'hfca8;
    wait_eval();
    wait_eval();
    wait_eval();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pressed = 16'h0000;
    @(negedge clk);
    vectors++;
    if ({col_o, key_down, key_valid, fifo_cnt, overflow} !== {4'hf, 16'h0, 1'b0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_event: got col=%b kd=%h v=%b cnt=%0d ovf=%b", col_o, key_down, key_valid, fifo_cnt, overflow);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (col_o !== 4'b1110) begin
      errors++;
      $display("FAIL reset_restart: got %b want 1110", col_o);
    end
    repeat (4) wait_sof();
    vectors++;
    if ({key_down, fifo_cnt} !== {16'h0, 3'd0}) begin
      errors++;
      $display("FAIL reset_no_partial: got kd=%h cnt=%0d want 0000 0", key_down, fifo_cnt);
    end
  endtask
  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_back_to_back();
    test_overflow();
    test_reset_in_event();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
